// File: rtl/multisim_apb_server_fsm.sv
// APB subordinate transfer engine for the multisim co-simulation bridge.
// Each APB transfer pushes one request word to the transport and pulls one
// response word back. The response is returned on PREADY.
// Optional: define MULTISIM_APB_TIMEOUT_EN to end a stuck ACCESS phase with
// SLVERR after TIMEOUT_CYCLES cycles.
module multisim_apb_server_fsm #(
    parameter int REQ_WIDTH      = 72,
    parameter int RESP_WIDTH     = 33,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQ_WIDTH-1:0]  i_apb_s_req,
    input  logic                  i_apb_s_psel,
    output logic [RESP_WIDTH-1:0] o_apb_s_resp,
    output logic                  o_apb_s_pready,
    output logic                  o_req_vld,
    input  logic                  i_req_rdy,
    output logic [REQ_WIDTH-1:0]  o_req_data,
    input  logic                  i_rsp_vld,
    output logic                  o_rsp_rdy,
    input  logic [RESP_WIDTH-1:0] i_rsp_data,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   req_sent_q;
    logic   req_sent_d;
    logic   rsp_take;
    logic   timeout_hit;

`ifdef MULTISIM_APB_TIMEOUT_EN
    logic [31:0] timeout_cnt_q;

    // ACCESS-phase watchdog: cleared on the way into ACCESS, counts stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            timeout_cnt_q <= '0;
        end else if ((state_q == ACCESS) && !o_apb_s_pready) begin
            timeout_cnt_q <= timeout_cnt_q + 32'd1;
        end
    end

    assign timeout_hit = (state_q == ACCESS) && (timeout_cnt_q == 32'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
`endif

    // Push channel: request is offered from SETUP until the transport takes it
    assign o_req_data = i_apb_s_req;
    assign o_req_vld  = (state_q == SETUP) || ((state_q == ACCESS) && !req_sent_q);

    // Pull channel: a response is only taken once the request has gone out
    assign o_rsp_rdy      = (state_q == ACCESS) && req_sent_q;
    assign rsp_take       = o_rsp_rdy && i_rsp_vld;
    assign o_apb_s_pready = rsp_take || timeout_hit;
    assign o_state        = state_q;

    // Response mux: real response wins; watchdog expiry answers with SLVERR only
    always_comb begin
        o_apb_s_resp = '0;
        if (rsp_take) begin
            o_apb_s_resp = i_rsp_data;
        end else if (timeout_hit) begin
            o_apb_s_resp = RESP_WIDTH'(1);
        end
    end

    // Next-state and request-sent tracking
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_apb_s_psel) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (o_apb_s_pready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_sent_d = req_sent_q || (o_req_vld && i_req_rdy);
        if (state_d == IDLE) begin
            req_sent_d = 1'b0;
        end
    end

    // State register; reset drops any transfer in flight without PREADY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_sent_q <= req_sent_d;
        end
    end

endmodule

// File: tb/tb_multisim_apb_server_fsm.sv
// Directed self-checking bench for multisim_apb_server_fsm.
// Inputs change 2ns after the rising edge; outputs are checked 1ns later.
module tb_multisim_apb_server_fsm;

    localparam int RQW = 72;
    localparam int RSW = 33;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [RQW-1:0] req;
    logic           psel;
    logic [RSW-1:0] resp;
    logic           pready;
    logic           req_vld;
    logic           req_rdy;
    logic [RQW-1:0] req_data;
    logic           rsp_vld;
    logic           rsp_rdy;
    logic [RSW-1:0] rsp_data;
    logic [1:0]     state;

    int n_cmp = 0;
    int n_err = 0;
    int req_hs = 0;
    int rsp_hs = 0;

    multisim_apb_server_fsm #(
        .REQ_WIDTH(RQW), .RESP_WIDTH(RSW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_apb_s_req(req), .i_apb_s_psel(psel),
        .o_apb_s_resp(resp), .o_apb_s_pready(pready),
        .o_req_vld(req_vld), .i_req_rdy(req_rdy), .o_req_data(req_data),
        .i_rsp_vld(rsp_vld), .o_rsp_rdy(rsp_rdy), .i_rsp_data(rsp_data),
        .o_state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req_vld && req_rdy) req_hs <= req_hs + 1;
        if (rsp_rdy && rsp_vld) rsp_hs <= rsp_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel = 1'b1; req = '1; req_rdy = 1'b1; rsp_vld = 1'b1; rsp_data = '1;
        tick(); tick(); #1;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL rst_pready got=%b exp=0", pready); end
        n_cmp++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL rst_req_vld got=%b exp=0", req_vld); end
        n_cmp++; if (rsp_rdy !== 1'b0) begin n_err++; $display("FAIL rst_rsp_rdy got=%b exp=0", rsp_rdy); end
        n_cmp++; if (resp !== '0) begin n_err++; $display("FAIL rst_resp got=%h exp=0", resp); end
        psel = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int h0;
        h0 = rsp_hs;
        psel = 1'b1; req = 72'h12_3456_789A_BCDE_F01; req_rdy = 1'b1; rsp_vld = 1'b1; rsp_data = 33'h0_DEAD_BEEF;
        req = 72'h1_2345_6789_ABCD_EF01;
        #1;
        n_cmp++; if (state !== 2'd0 || req_vld !== 1'b0) begin n_err++; $display("FAIL single_c1 state=%0d req_vld=%b exp 0/0", state, req_vld); end
        tick(); #1;
        n_cmp++; if (state !== 2'd1 || req_vld !== 1'b1) begin n_err++; $display("FAIL single_c2 state=%0d req_vld=%b exp 1/1", state, req_vld); end
        n_cmp++; if (req_data !== 72'h1_2345_6789_ABCD_EF01) begin n_err++; $display("FAIL single_data got=%h exp=123456789abcdef01", req_data); end
        n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL single_early_pready got=%b exp=0", pready); end
        tick(); #1;
        n_cmp++; if (state !== 2'd2 || pready !== 1'b1) begin n_err++; $display("FAIL single_c3 state=%0d pready=%b exp 2/1", state, pready); end
        n_cmp++; if (resp !== 33'h0_DEAD_BEEF) begin n_err++; $display("FAIL single_resp got=%h exp=0deadbeef", resp); end
        n_cmp++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL single_req_vld_c3 got=%b exp=0", req_vld); end
        tick();
        psel = 1'b0; rsp_vld = 1'b0; #1;
        n_cmp++; if (state !== 2'd0 || pready !== 1'b0) begin n_err++; $display("FAIL single_c4 state=%0d pready=%b exp 0/0", state, pready); end
        n_cmp++; if (rsp_hs !== h0 + 1) begin n_err++; $display("FAIL single_rsp_hs got=%0d exp=%0d", rsp_hs - h0, 1); end
        tick();
    endtask

    task automatic test_push_stall();
        int h0;
        h0 = req_hs;
        psel = 1'b1; req = 72'hAA_0000_0000_0000_0055; req_rdy = 1'b0; rsp_vld = 1'b1; rsp_data = 33'h1_0000_0001;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (req_vld !== 1'b1 || rsp_rdy !== 1'b0 || pready !== 1'b0) begin
                n_err++; $display("FAIL push_stall_c%0d req_vld=%b rsp_rdy=%b pready=%b exp 1/0/0", i, req_vld, rsp_rdy, pready);
            end
            tick();
        end
        req_rdy = 1'b1; #1;
        n_cmp++; if (state !== 2'd2 || req_vld !== 1'b1 || pready !== 1'b0) begin n_err++; $display("FAIL push_accept state=%0d req_vld=%b pready=%b exp 2/1/0", state, req_vld, pready); end
        tick(); #1;
        n_cmp++; if (pready !== 1'b1 || resp !== 33'h1_0000_0001) begin n_err++; $display("FAIL push_done pready=%b resp=%h exp 1/100000001", pready, resp); end
        n_cmp++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL push_req_vld_after got=%b exp=0", req_vld); end
        tick();
        psel = 1'b0; rsp_vld = 1'b0; #1;
        n_cmp++; if (req_hs !== h0 + 1) begin n_err++; $display("FAIL push_req_hs got=%0d exp=1", req_hs - h0); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL push_idle got=%0d exp=0", state); end
        tick();
    endtask

    task automatic test_pull_stall();
        psel = 1'b1; req = 72'h0F_F0F0_F0F0_F0F0_F0F0; req_rdy = 1'b1; rsp_vld = 1'b0; rsp_data = 33'h0_1234_5678;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if (state !== 2'd2 || req_vld !== 1'b0 || rsp_rdy !== 1'b1 || pready !== 1'b0) begin
                n_err++; $display("FAIL pull_wait_c%0d state=%0d req_vld=%b rsp_rdy=%b pready=%b exp 2/0/1/0", i, state, req_vld, rsp_rdy, pready);
            end
            tick();
        end
        rsp_vld = 1'b1; #1;
        n_cmp++; if (pready !== 1'b1 || resp !== 33'h0_1234_5678) begin n_err++; $display("FAIL pull_done pready=%b resp=%h exp 1/012345678", pready, resp); end
        tick();
        psel = 1'b0; rsp_vld = 1'b0; #1;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL pull_idle got=%0d exp=0", state); end
        tick();
    endtask

    task automatic test_back_to_back();
        int rq0, rs0;
        logic [RQW-1:0] rq;
        logic [RSW-1:0] rs;
        rq0 = req_hs; rs0 = rsp_hs;
        psel = 1'b1; req_rdy = 1'b1; rsp_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rq = RQW'(64'hC0DE_0000_0000_0000 + k);
            rs = RSW'(33'h1_0000_0010 + k);
            req = rq; rsp_data = rs; #1;
            n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL b2b_%0d_s0 got=%0d exp=0", k, state); end
            tick(); #1;
            n_cmp++; if (state !== 2'd1 || req_data !== rq) begin n_err++; $display("FAIL b2b_%0d_s1 state=%0d data=%h exp 1/%h", k, state, req_data, rq); end
            tick(); #1;
            n_cmp++; if (state !== 2'd2 || pready !== 1'b1 || resp !== rs) begin n_err++; $display("FAIL b2b_%0d_s2 state=%0d pready=%b resp=%h exp 2/1/%h", k, state, pready, resp, rs); end
            tick();
        end
        psel = 1'b0; rsp_vld = 1'b0; #1;
        n_cmp++; if (req_hs !== rq0 + 4 || rsp_hs !== rs0 + 4) begin n_err++; $display("FAIL b2b_hs req=%0d rsp=%0d exp 4/4", req_hs - rq0, rsp_hs - rs0); end
        tick(); #1;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL b2b_end got=%0d exp=0", state); end
        tick();
    endtask

    task automatic test_psel_drop();
        psel = 1'b1; req = 72'h5; req_rdy = 1'b1; rsp_vld = 1'b1; rsp_data = 33'h0_0000_0777;
        tick();
        psel = 1'b0; #1;
        n_cmp++; if (state !== 2'd1 || req_vld !== 1'b1) begin n_err++; $display("FAIL drop_setup state=%0d req_vld=%b exp 1/1", state, req_vld); end
        tick(); #1;
        n_cmp++; if (state !== 2'd2 || pready !== 1'b1 || resp !== 33'h0_0000_0777) begin n_err++; $display("FAIL drop_access state=%0d pready=%b resp=%h exp 2/1/777", state, pready, resp); end
        tick();
        rsp_vld = 1'b0; #1;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL drop_idle got=%0d exp=0", state); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int rs0;
        int wait_n;
        wait_n = $urandom_range(1, 4);
        psel = 1'b1; req = 72'h9; req_rdy = 1'b1; rsp_vld = 1'b0; rsp_data = 33'h0_0000_0099;
        tick(); tick();
        for (int i = 0; i < wait_n; i++) tick();
        #($urandom_range(1, 3));
        rs0 = rsp_hs;
        rst_n = 1'b0; #1;
        n_cmp++; if (state !== 2'd0 || pready !== 1'b0 || req_vld !== 1'b0 || rsp_rdy !== 1'b0) begin
            n_err++; $display("FAIL midrst state=%0d pready=%b req_vld=%b rsp_rdy=%b exp 0/0/0/0", state, pready, req_vld, rsp_rdy);
        end
        psel = 1'b0; rsp_vld = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); #1;
        n_cmp++; if (state !== 2'd0 || rsp_hs !== rs0 || pready !== 1'b0) begin
            n_err++; $display("FAIL midrst_after state=%0d pulls=%0d pready=%b exp 0/0/0", state, rsp_hs - rs0, pready);
        end
        rsp_vld = 1'b0;
        tick();
    endtask

`ifdef MULTISIM_APB_TIMEOUT_EN
    task automatic test_timeout();
        psel = 1'b1; req = 72'h7; req_rdy = 1'b1; rsp_vld = 1'b0; rsp_data = '0;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (state !== 2'd2 || pready !== 1'b0) begin n_err++; $display("FAIL tmo_wait_c%0d state=%0d pready=%b exp 2/0", i, state, pready); end
            tick();
        end
        #1;
        n_cmp++; if (pready !== 1'b1 || resp !== 33'h1) begin n_err++; $display("FAIL tmo_fire pready=%b resp=%h exp 1/000000001", pready, resp); end
        tick();
        psel = 1'b0; #1;
        n_cmp++; if (state !== 2'd0 || pready !== 1'b0) begin n_err++; $display("FAIL tmo_idle state=%0d pready=%b exp 0/0", state, pready); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_push_stall();
        test_pull_stall();
        test_back_to_back();
        test_psel_drop();
        test_reset_mid_access();
`ifdef MULTISIM_APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
